uart_rx: RTL and testbench

UART receive engine for the serial link: it oversamples the asynchronous `rx` pin with the system clock, detects a start bit, samples each bit at mid-period and delivers the assembled word with parity and framing status. It is the receive-side counterpart of the transmitter path. It sits between the pad and the RX FIFO or register interface, and it generates its own bit timing from `CLKS_PER_BIT`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 41 ++++
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Desc     : Types and constants shared by the UART transmit and receive
//             engines.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 50 MHz system clock / 115200 baud.
    localparam int unsigned c_CLKS_PER_BIT = 434;

    // Receive engine states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Desc     : Double-flop synchronizer for asynchronous inputs, with a
//             configurable reset value so idle-high lines stay idle in reset.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values: each stage simply takes the previous one.
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Synchronizer flops, reset to the line's idle value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Desc     : UART receive engine. Oversamples the rx pin, detects the start
//             edge, samples every bit at mid-period and delivers the word with
//             parity and framing status on a one-cycle valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT,  // >= 4
    parameter int unsigned DATA_BITS    = 8,               // 5..9
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1                // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [IDX_W-1:0] c_idx_data = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_idx_stop = IDX_W'(STOP_BITS - 1);
    localparam logic             c_par_odd  = (PARITY_ODD != 0);
    localparam rx_state_t        c_after_data = (PARITY_EN != 0) ? PARITY : STOP;

    logic w_rx_sync;
    logic w_fall;
    logic w_half_hit;
    logic w_full_hit;
    logic w_stop_low;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 par_fail_q, par_fail_d;
    logic                 stop_fail_q, stop_fail_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 valid_q, valid_d;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_sync)
    );

    // A start edge is a high-to-low transition of the synchronized line;
    // a line held low (break) therefore never re-triggers until it rises.
    assign w_fall     = rx_prev_q & ~w_rx_sync;
    assign w_half_hit = (cnt_q == c_cnt_half);
    assign w_full_hit = (cnt_q == c_cnt_full);
    assign w_stop_low = stop_fail_q | ~w_rx_sync;

    // Next-state, bit timing, shift register and result capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        rx_prev_d    = w_rx_sync;
        par_fail_d   = par_fail_q;
        stop_fail_d  = stop_fail_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        valid_d      = 1'b0;

        if (!en) begin
            // Abandon any frame in flight; delivered results stay put.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (w_fall) begin
                        state_d     = START;
                        par_fail_d  = 1'b0;
                        stop_fail_d = 1'b0;
                    end
                end
                START: begin
                    if (w_half_hit) begin
                        cnt_d = '0;
                        // A line already back high mid start bit is a glitch.
                        state_d = w_rx_sync ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_full_hit) begin
                        cnt_d   = '0;
                        shift_d = {w_rx_sync, shift_q[DATA_BITS-1:1]};
                        if (idx_q == c_idx_data) begin
                            idx_d   = '0;
                            state_d = c_after_data;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (w_full_hit) begin
                        cnt_d      = '0;
                        par_fail_d = (^shift_q) ^ w_rx_sync ^ c_par_odd;
                        state_d    = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_full_hit) begin
                        cnt_d       = '0;
                        stop_fail_d = w_stop_low;
                        if (idx_q == c_idx_stop) begin
                            // Leave at mid stop bit so the next start edge is caught.
                            idx_d        = '0;
                            state_d      = IDLE;
                            data_out_d   = shift_q;
                            parity_err_d = par_fail_q;
                            frame_err_d  = w_stop_low;
                            valid_d      = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_prev_q    <= 1'b1;
            par_fail_q   <= 1'b0;
            stop_fail_q  <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_prev_q    <= rx_prev_d;
            par_fail_q   <= par_fail_d;
            stop_fail_q  <= stop_fail_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            valid_q      <= valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Desc     : Self-checking bench for uart_rx. One 8N1 and one 8E1 receiver
//             are driven with serial frames; expected words, flags and valid
//             cycle are queued at send time and matched on each valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;

    typedef struct packed {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        logic [31:0] cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_n, rx_e;
    logic       en_n, en_e;
    logic [7:0] data_out_n, data_out_e;
    logic       valid_n, valid_e;
    logic       parity_err_n, parity_err_e;
    logic       frame_err_n, frame_err_e;
    logic       busy_n, busy_e;

    int unsigned cyc;
    int          n_vec;
    int          n_err;
    exp_t        q_n[$];
    exp_t        q_e[$];
    exp_t        mon_n, mon_e;
    exp_t        last_n;

    uart_rx #(
        .CLKS_PER_BIT (N), .DATA_BITS (8), .PARITY_EN (0),
        .PARITY_ODD (0), .STOP_BITS (1)
    ) u_dut_n (
        .clk (clk), .rst_n (rst_n), .rx (rx_n), .en (en_n),
        .data_out (data_out_n), .valid (valid_n),
        .parity_err (parity_err_n), .frame_err (frame_err_n), .busy (busy_n)
    );

    uart_rx #(
        .CLKS_PER_BIT (N), .DATA_BITS (8), .PARITY_EN (1),
        .PARITY_ODD (0), .STOP_BITS (1)
    ) u_dut_e (
        .clk (clk), .rst_n (rst_n), .rx (rx_e), .en (en_e),
        .data_out (data_out_e), .valid (valid_e),
        .parity_err (parity_err_e), .frame_err (frame_err_e), .busy (busy_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame on the 8N1 (sel=0) or 8E1 (sel=1) line. cut_kind 1
    // drops en_n, cut_kind 2 pulses reset, half-way into data bit cut_bit.
    task automatic send(input bit sel, input logic [7:0] d, input logic pbit,
                        input logic stop_v, input int cut_bit, input int cut_kind,
                        input bit push);
        logic [10:0] bits;
        int          nb;
        exp_t        item;
        bits = {stop_v, pbit, d, 1'b0};
        if (!sel) bits[9] = stop_v;
        nb = sel ? 11 : 10;
        if (push) begin
            item.data = d;
            item.perr = sel ? ((^d) ^ pbit) : 1'b0;
            item.ferr = ~stop_v;
            item.cyc  = 32'(cyc + 2 + H + (9 + int'(sel)) * N + 1);
            if (sel) q_e.push_back(item);
            else begin
                q_n.push_back(item);
                last_n = item;
            end
        end
        for (int b = 0; b < nb; b++) begin
            if (sel) rx_e = bits[b];
            else     rx_n = bits[b];
            for (int c = 0; c < N; c++) begin
                if (cut_kind != 0 && b == cut_bit + 1 && c == H) begin
                    if (cut_kind == 1) begin
                        en_n = 1'b0;
                        @(posedge clk);
                        #1;
                        chk("abort_busy", {31'b0, busy_n}, 0);
                        chk("abort_valid", {31'b0, valid_n}, 0);
                        chk("abort_data_hold", {24'b0, data_out_n}, {24'b0, last_n.data});
                        chk("abort_ferr_hold", {31'b0, frame_err_n}, {31'b0, last_n.ferr});
                    end else begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_mid_data", {24'b0, data_out_n}, 0);
                        chk("rst_mid_busy", {31'b0, busy_n}, 0);
                        chk("rst_mid_valid", {31'b0, valid_n}, 0);
                        chk("rst_mid_ferr", {31'b0, frame_err_n}, 0);
                        chk("rst_mid_perr", {31'b0, parity_err_n}, 0);
                        @(posedge clk);
                        #1;
                        rst_n  = 1'b1;
                        last_n = '0;
                    end
                    rx_n = 1'b1;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && valid_n) begin
            if (q_n.size() == 0) chk("n_unexpected_valid", {31'b0, valid_n}, 0);
            else begin
                mon_n = q_n.pop_front();
                chk("n_data", {24'b0, data_out_n}, {24'b0, mon_n.data});
                chk("n_perr", {31'b0, parity_err_n}, {31'b0, mon_n.perr});
                chk("n_ferr", {31'b0, frame_err_n}, {31'b0, mon_n.ferr});
                chk("n_valid_cycle", cyc, mon_n.cyc);
            end
        end
        if (rst_n && valid_e) begin
            if (q_e.size() == 0) chk("e_unexpected_valid", {31'b0, valid_e}, 0);
            else begin
                mon_e = q_e.pop_front();
                chk("e_data", {24'b0, data_out_e}, {24'b0, mon_e.data});
                chk("e_perr", {31'b0, parity_err_e}, {31'b0, mon_e.perr});
                chk("e_ferr", {31'b0, frame_err_e}, {31'b0, mon_e.ferr});
                chk("e_valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        cyc    = 0;
        n_vec  = 0;
        n_err  = 0;
        last_n = '0;
        rst_n  = 1'b0;
        rx_n   = 1'b1;
        rx_e   = 1'b1;
        en_n   = 1'b1;
        en_e   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_n", {24'b0, data_out_n}, 0);
        chk("rst_valid_n", {31'b0, valid_n}, 0);
        chk("rst_perr_n", {31'b0, parity_err_n}, 0);
        chk("rst_ferr_n", {31'b0, frame_err_n}, 0);
        chk("rst_busy_n", {31'b0, busy_n}, 0);
        chk("rst_data_e", {24'b0, data_out_e}, 0);
        chk("rst_busy_e", {31'b0, busy_e}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // 8N1 reference frame with latency check.
        send(0, 8'hA5, 1'b0, 1'b1, 0, 0, 1);
        idle(N);

        // Short low pulse must be rejected as a glitch.
        rx_n = 1'b0;
        idle(3);
        rx_n = 1'b1;
        chk("glitch_busy", {31'b0, busy_n}, 1);
        idle(N);
        chk("glitch_idle", {31'b0, busy_n}, 0);

        // Even parity: wrong, then correct parity bit.
        send(1, 8'h03, 1'b1, 1'b1, 0, 0, 1);
        send(1, 8'h03, 1'b0, 1'b1, 0, 0, 1);
        send(1, 8'h07, 1'b1, 1'b1, 0, 0, 1);
        idle(N);

        // Break: stop bit low, line stays low, no restart until it rises.
        send(0, 8'h5A, 1'b0, 1'b0, 0, 0, 1);
        idle(3 * N);
        chk("break_no_restart", {31'b0, busy_n}, 0);
        rx_n = 1'b1;
        idle(N);
        send(0, 8'h11, 1'b0, 1'b1, 0, 0, 1);
        idle(N);

        // Disable during data bit 4, then recover.
        send(0, 8'h77, 1'b0, 1'b1, 4, 1, 0);
        idle(2 * N);
        en_n = 1'b1;
        idle(N);
        send(0, 8'h3C, 1'b0, 1'b1, 0, 0, 1);

        // Back-to-back frames, no idle gap.
        send(0, 8'h00, 1'b0, 1'b1, 0, 0, 1);
        send(0, 8'hFF, 1'b0, 1'b1, 0, 0, 1);
        send(0, 8'h81, 1'b0, 1'b1, 0, 0, 1);
        idle(N);

        // Reset during data bit 3, then a clean frame.
        send(0, 8'hC3, 1'b0, 1'b1, 3, 2, 0);
        idle(2 * N);
        send(0, 8'h96, 1'b0, 1'b1, 0, 0, 1);
        idle(2 * N);

        chk("n_pending_frames", q_n.size(), 0);
        chk("e_pending_frames", q_e.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
